crc_append: RTL
===============

CRC_APPEND -- requirements
Module: crc_append

Interface
REQ-001 Parameter: CNT_W, default 16, width of the frame word counter.
REQ-002 clk  input  1  sole clock; all registers update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low; one clock only.
REQ-004 s_data  input  32  upstream payload word.
REQ-005 s_valid  input  1  upstream word present.
REQ-006 s_last  input  1  upstream word is the last payload word of its frame.
REQ-007 s_ready  output  1  block accepts the upstream word this cycle.
REQ-008 m_data  output  32  downstream word: payload, or the CRC trailer.
REQ-009 m_valid  output  1  downstream word present.
REQ-010 m_last  output  1  downstream word is the CRC trailer.
REQ-011 m_ready  input  1  downstream accepts the word.
REQ-012 crc_rst  output  1  synchronous seed request to the CRC unit.
REQ-013 crc_data  output  32  word fed to the CRC unit.
REQ-014 crc_valid  output  1  CRC unit advance strobe.
REQ-015 crc_in  input  32  current CRC unit register value; updates one cycle after crc_valid.
REQ-016 frame_len  output  CNT_W  payload word count of the last completed frame.
REQ-017 frame_done  output  1  one-cycle pulse when the trailer is loaded into the output register.

Function
REQ-018 The FSM SHALL have states INIT, IDLE, DATA and TAIL.
REQ-019 INIT SHALL last exactly one cycle after reset release, with crc_rst=1 and s_ready=0, then go to IDLE.
REQ-020 s_ready SHALL equal (state is IDLE or DATA) AND (m_valid=0 OR m_ready=1).
REQ-021 Accept is defined as s_valid AND s_ready.
REQ-022 crc_data SHALL equal s_data, combinationally.
REQ-023 crc_valid SHALL equal accept, combinationally.
REQ-024 On accept: m_data<=s_data, m_valid<=1, m_last<=0.
REQ-025 On m_valid AND m_ready with no new load: m_valid<=0.
REQ-026 Accept in IDLE SHALL set word_cnt<=1.
REQ-027 Accept in DATA SHALL increment word_cnt, saturating at all-ones.
REQ-028 State transition on accept: s_last=0 -> DATA; s_last=1 -> TAIL.
REQ-029 A frame may consist of a single word.
REQ-030 In TAIL with (m_valid=0 OR m_ready=1), the block SHALL load the trailer, in one cycle:
  - m_data<=crc_in, m_valid<=1, m_last<=1;
  - crc_rst=1, combinational, for that cycle only;
  - frame_len<=word_cnt, frame_done=1;
  - state -> IDLE.
REQ-031 crc_in SHALL be sampled in TAIL no earlier than one cycle after the final crc_valid; the TAIL entry cycle guarantees this.
REQ-032 crc_rst and crc_valid SHALL never be asserted in the same cycle.
REQ-033 crc_rst SHALL be 0 outside INIT and the trailer-load cycle.
REQ-034 Downstream throughput SHALL be one word per cycle when m_ready is held high; the trailer costs one extra cycle per frame.
REQ-035 Latency SHALL be one cycle from accept to m_valid; m_data SHALL be held stable while m_valid=1 and m_ready=0.
REQ-036 An IDLE accept may coincide with the downstream taking the trailer (same cycle).

Reset
REQ-037 While rst_n=0 the block SHALL hold:
  - m_valid=0, m_last=0, m_data=0;
  - frame_len=0, frame_done=0, word_cnt=0;
  - state=INIT.
REQ-038 Reset asserted mid-frame SHALL discard the partial frame with no trailer emitted, and re-seed the CRC via INIT.

Verification
REQ-039 Reset release, s_valid=1 -> s_ready=0 and crc_rst=1 for exactly one cycle, then s_ready=1.
REQ-040 Single-word frame 0x00000000 with s_last=1, m_ready=1 -> m_data=0x00000000 with m_last=0, then the trailer with m_last=1 equal to the golden-model CRC (seed 32'h52325032); frame_len=1; frame_done pulses once.
REQ-041 Four-word frame 0x11111111..0x44444444 back-to-back, m_ready=1 -> five consecutive output words; trailer matches the golden model; frame_len=4; crc_valid high for exactly 4 cycles.
REQ-042 Same frame with m_ready toggling 1,0,0,1,... -> s_ready=0 whenever m_valid=1 and m_ready=0; no word lost or duplicated; m_data stable while stalled; trailer unchanged.
REQ-043 Two frames back-to-back, the second starting in the trailer handoff cycle -> the second trailer is computed from the 32'h52325032 seed, independent of frame 1.
REQ-044 rst_n pulsed low after word 2 of a frame, then a full frame sent -> no trailer for the aborted frame; the new frame's trailer matches the golden model.

Source files
------------

// File: rtl/crc_append.sv
// Frame packer that passes payload words through a one-deep output register and
// appends the external CRC unit's value as a trailer word after each frame.
module crc_append #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [31:0]      s_data,
   input  logic             s_valid,
   input  logic             s_last,
   output logic             s_ready,
   output logic [31:0]      m_data,
   output logic             m_valid,
   output logic             m_last,
   input  logic             m_ready,
   output logic             crc_rst,
   output logic [31:0]      crc_data,
   output logic             crc_valid,
   input  logic [31:0]      crc_in,
   output logic [CNT_W-1:0] frame_len,
   output logic             frame_done
);

   typedef enum logic [1:0] {
      INIT,
      IDLE,
      DATA,
      TAIL
   } state_t;

   state_t             state_q, state_d;
   logic [31:0]        m_data_q, m_data_d;
   logic               m_valid_q, m_valid_d;
   logic               m_last_q, m_last_d;
   logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
   logic [CNT_W-1:0]   frame_len_q, frame_len_d;

   logic out_free;
   logic accept;
   logic load_trailer;

   always_comb begin
      // NOTE: every signal gets a default before any branch, so no latch can be inferred.
      state_d     = state_q;
      m_data_d    = m_data_q;
      m_valid_d   = m_valid_q;
      m_last_d    = m_last_q;
      word_cnt_d  = word_cnt_q;
      frame_len_d = frame_len_q;

      // The output register can take a new word when empty or draining this cycle.
      out_free     = !m_valid_q || m_ready;
      s_ready      = ((state_q == IDLE) || (state_q == DATA)) && out_free;
      accept       = s_valid && s_ready;
      load_trailer = (state_q == TAIL) && out_free;

      if (m_valid_q && m_ready) begin
         m_valid_d = 1'b0;
         m_last_d  = 1'b0;
      end

      case (state_q)
         INIT: state_d = IDLE;
         IDLE, DATA: begin
            if (accept) begin
               m_data_d  = s_data;
               m_valid_d = 1'b1;
               m_last_d  = 1'b0;
               if (state_q == IDLE) begin
                  word_cnt_d = CNT_W'(1);
               end else if (!(&word_cnt_q)) begin
                  word_cnt_d = word_cnt_q + CNT_W'(1);
               end
               state_d = s_last ? TAIL : DATA;
            end
         end
         TAIL: begin
            // crc_in already includes the last word: it was accepted on the edge entering TAIL.
            if (load_trailer) begin
               m_data_d    = crc_in;
               m_valid_d   = 1'b1;
               m_last_d    = 1'b1;
               frame_len_d = word_cnt_q;
               state_d     = IDLE;
            end
         end
      endcase

      crc_data   = s_data;
      crc_valid  = accept;
      crc_rst    = (state_q == INIT) || load_trailer;
      frame_done = load_trailer;
   end

   // NOTE: sequential state uses non-blocking assignments only, so all flops sample together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= INIT;
         m_data_q    <= '0;
         m_valid_q   <= 1'b0;
         m_last_q    <= 1'b0;
         word_cnt_q  <= '0;
         frame_len_q <= '0;
      end else begin
         state_q     <= state_d;
         m_data_q    <= m_data_d;
         m_valid_q   <= m_valid_d;
         m_last_q    <= m_last_d;
         word_cnt_q  <= word_cnt_d;
         frame_len_q <= frame_len_d;
      end
   end

   assign m_data    = m_data_q;
   assign m_valid   = m_valid_q;
   assign m_last    = m_last_q;
   assign frame_len = frame_len_q;

endmodule
